// File: rtl/data_memory_arbiter.sv
// -----------------------------------------------------------------------------
// data_memory_arbiter
//
// Shares the single combinational Data_Memory port between the instruction
// fetch unit and the load/store unit. One requester is granted at a time; the
// memory address, write data and RD/WR selectors are held for WAIT_CYCLES+1
// cycles, the read data is registered and returned with a one-cycle ack.
// Load/store has priority, but a fetch that is waiting always wins right after
// an LS grant, so continuous contention alternates LS, F, LS, F, ...
//
// Optional feature macro: DATA_MEMORY_ARBITER_ALIGN_CHECK_EN
//   defined   : a granted access with address[1:0] != 0 skips the memory and
//               completes immediately (LS_Ack + LS_Error for LS, Fetch_Ack only
//               for fetch); *_Data_Out is left unchanged.
//   undefined : LS_Error is tied 0, every address goes to memory unchanged.
//
// Parameters
//   DATAWIDTH_BUS : width of address and data buses (>= 2)
//   WAIT_CYCLES   : extra cycles the bus is held before capture (0..15)
//
// Ports
//   MemArbiter_CLOCK_50     in   system clock, rising edge
//   MemArbiter_RESET_InLow  in   asynchronous active-low reset
//   Fetch_Req/Address_In    in   fetch request (held until Fetch_Ack) + address
//   Fetch_Ack/Data_Out      out  completion pulse + registered instruction word
//   LS_Req/WR/Address_In/Data_In  in  load/store request, 1=store, address, data
//   LS_Ack/Data_Out/Error   out  completion pulse, registered load data, misalign
//   DataMemory_*_Out        out  memory address, write data, RD and WR selects
//   DataMemory_Data_In      in   combinational read data from memory
//   MemArbiter_Busy         out  high while an access is in ACCESS or DONE
// -----------------------------------------------------------------------------
module data_memory_arbiter #(
  parameter int unsigned DATAWIDTH_BUS = 32,
  parameter int unsigned WAIT_CYCLES   = 1
) (
  input  logic                     MemArbiter_CLOCK_50,
  input  logic                     MemArbiter_RESET_InLow,
  // Fetch port
  input  logic                     Fetch_Req,
  input  logic [DATAWIDTH_BUS-1:0] Fetch_Address_In,
  output logic                     Fetch_Ack,
  output logic [DATAWIDTH_BUS-1:0] Fetch_Data_Out,
  // Load/store port
  input  logic                     LS_Req,
  input  logic                     LS_WR,
  input  logic [DATAWIDTH_BUS-1:0] LS_Address_In,
  input  logic [DATAWIDTH_BUS-1:0] LS_Data_In,
  output logic                     LS_Ack,
  output logic [DATAWIDTH_BUS-1:0] LS_Data_Out,
  output logic                     LS_Error,
  // Memory side
  output logic [DATAWIDTH_BUS-1:0] DataMemory_Address_Out,
  output logic [DATAWIDTH_BUS-1:0] DataMemory_WrData_Out,
  output logic                     DataMemory_Selector_RD,
  output logic                     DataMemory_Selector_WR,
  input  logic [DATAWIDTH_BUS-1:0] DataMemory_Data_In,
  // Status
  output logic                     MemArbiter_Busy
);

  // Counter holds WAIT_CYCLES, which is legal only up to 15.
  localparam logic [3:0] WaitLoad = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StDone   = 2'd2
  } state_e;

  state_e                   r_state;
  logic [3:0]               r_count;
  logic                     r_last_ls;   // last grant went to LS (reset: fetch)
  logic                     r_grant_ls;  // port owning the current access
  logic [DATAWIDTH_BUS-1:0] r_mem_addr;
  logic [DATAWIDTH_BUS-1:0] r_mem_wdata;
  logic                     r_sel_rd;
  logic                     r_sel_wr;
  logic [DATAWIDTH_BUS-1:0] r_fetch_data;
  logic [DATAWIDTH_BUS-1:0] r_ls_data;
  logic                     r_fetch_ack;
  logic                     r_ls_ack;
  logic                     r_busy;

  logic                     w_req_any;
  logic                     w_grant_ls;
  logic                     w_grant_wr;
  logic                     w_misaligned;
  logic [DATAWIDTH_BUS-1:0] w_grant_addr;
  logic [DATAWIDTH_BUS-1:0] w_grant_wdata;

  // ---------------------------------------------------------------------------
  // Grant decision, only consumed in IDLE.
  // LS wins by default; a pending fetch wins only if LS had the last grant.
  // ---------------------------------------------------------------------------
  assign w_req_any     = Fetch_Req | LS_Req;
  assign w_grant_ls    = LS_Req & ~(r_last_ls & Fetch_Req);
  assign w_grant_addr  = w_grant_ls ? LS_Address_In : Fetch_Address_In;
  assign w_grant_wdata = w_grant_ls ? LS_Data_In : '0;
  assign w_grant_wr    = w_grant_ls & LS_WR;  // fetches are always reads

`ifdef DATA_MEMORY_ARBITER_ALIGN_CHECK_EN
  assign w_misaligned = |w_grant_addr[1:0];
`else
  assign w_misaligned = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Main FSM. All outputs are registered here, so the memory bus, acks and
  // busy change only on clock edges and clear asynchronously on reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge MemArbiter_CLOCK_50 or negedge MemArbiter_RESET_InLow) begin
    if (!MemArbiter_RESET_InLow) begin
      r_state      <= StIdle;
      r_count      <= 4'd0;
      r_last_ls    <= 1'b0;
      r_grant_ls   <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_sel_rd     <= 1'b0;
      r_sel_wr     <= 1'b0;
      r_fetch_data <= '0;
      r_ls_data    <= '0;
      r_fetch_ack  <= 1'b0;
      r_ls_ack     <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      // Acks are single-cycle pulses by default.
      r_fetch_ack <= 1'b0;
      r_ls_ack    <= 1'b0;

      unique case (r_state)
        StIdle: begin
          if (w_req_any) begin
            r_last_ls  <= w_grant_ls;
            r_grant_ls <= w_grant_ls;
            r_busy     <= 1'b1;
            if (w_misaligned) begin
              // Never touches memory; complete straight away.
              r_state     <= StDone;
              r_ls_ack    <= w_grant_ls;
              r_fetch_ack <= ~w_grant_ls;
            end else begin
              r_state     <= StAccess;
              r_count     <= WaitLoad;
              r_mem_addr  <= w_grant_addr;
              r_mem_wdata <= w_grant_wdata;
              r_sel_rd    <= ~w_grant_wr;
              r_sel_wr    <= w_grant_wr;
            end
          end
        end

        StAccess: begin
          if (r_count != 4'd0) begin
            r_count <= r_count - 4'd1;
          end else begin
            // Memory is combinational: data is valid for the whole hold window.
            if (r_sel_rd) begin
              if (r_grant_ls) begin
                r_ls_data <= DataMemory_Data_In;
              end else begin
                r_fetch_data <= DataMemory_Data_In;
              end
            end
            r_ls_ack    <= r_grant_ls;
            r_fetch_ack <= ~r_grant_ls;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_sel_rd    <= 1'b0;
            r_sel_wr    <= 1'b0;
            r_state     <= StDone;
          end
        end

        StDone: begin
          // No grant here: back-to-back accesses pay one IDLE sampling cycle.
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

`ifdef DATA_MEMORY_ARBITER_ALIGN_CHECK_EN
  logic r_ls_err;

  // Pulses together with LS_Ack for a misaligned LS grant only.
  always_ff @(posedge MemArbiter_CLOCK_50 or negedge MemArbiter_RESET_InLow) begin
    if (!MemArbiter_RESET_InLow) begin
      r_ls_err <= 1'b0;
    end else begin
      r_ls_err <= (r_state == StIdle) & w_req_any & w_grant_ls & w_misaligned;
    end
  end

  assign LS_Error = r_ls_err;
`else
  assign LS_Error = 1'b0;
`endif

  assign Fetch_Ack              = r_fetch_ack;
  assign Fetch_Data_Out         = r_fetch_data;
  assign LS_Ack                 = r_ls_ack;
  assign LS_Data_Out            = r_ls_data;
  assign DataMemory_Address_Out = r_mem_addr;
  assign DataMemory_WrData_Out  = r_mem_wdata;
  assign DataMemory_Selector_RD = r_sel_rd;
  assign DataMemory_Selector_WR = r_sel_wr;
  assign MemArbiter_Busy        = r_busy;

`ifndef SYNTHESIS
  a_sel_onehot : assert property (@(posedge MemArbiter_CLOCK_50)
      disable iff (!MemArbiter_RESET_InLow) !(r_sel_rd && r_sel_wr));
  a_ack_excl : assert property (@(posedge MemArbiter_CLOCK_50)
      disable iff (!MemArbiter_RESET_InLow) !(r_fetch_ack && r_ls_ack));
`endif

endmodule

// File: tb/tb_data_memory_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_memory_arbiter
//
// Scoreboard bench: every issued request pushes its expected response into a
// per-port queue; a monitor pops and compares on each ack. The reference model
// is a plain word array updated in request order. A second instance with
// WAIT_CYCLES=0 covers the zero-wait latency case.
// -----------------------------------------------------------------------------
module tb_data_memory_arbiter;

  localparam int unsigned W = 1;

`ifdef DATA_MEMORY_ARBITER_ALIGN_CHECK_EN
  localparam bit AlignEn = 1'b1;
`else
  localparam bit AlignEn = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } ls_exp_t;

  typedef struct packed {
    logic        ls;
    logic [31:0] cyc;
  } ack_rec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_req, ls_req, ls_wr;
  logic [31:0] f_addr, ls_addr, ls_wdata;
  logic        f_ack, ls_ack, ls_err, m_rd, m_wr, busy;
  logic [31:0] f_data, ls_data, m_addr, m_wdata, m_rdata;

  // WAIT_CYCLES = 0 instance
  logic        z_ls_req;
  logic [31:0] z_ls_addr;
  logic        z_f_ack, z_ls_ack, z_ls_err, z_rd, z_wr, z_busy;
  logic [31:0] z_f_data, z_ls_data, z_addr, z_wdata, z_rdata;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [31:0] wmem   [1024];
  bit          wvalid [1024];
  logic [31:0] ref_mem[1024];
  logic [31:0] m_ls_last, m_f_last;
  logic [31:0] exp_f[$];
  ls_exp_t     exp_ls[$];
  ack_rec_t    ack_log[$];

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input logic [9:0] i);
    case (i)
      10'h000: return 32'h1080_0800;
      10'h002: return 32'h0000_000A;
      10'h200: return 32'hC200_2004;
      default: return ({22'd0, i} * 32'h9E37_79B1) ^ 32'h00C0_FFEE;
    endcase
  endfunction

  // Combinational memory: written words override the initial image.
  assign m_rdata = wvalid[m_addr[11:2]] ? wmem[m_addr[11:2]] : init_word(m_addr[11:2]);
  assign z_rdata = init_word(z_addr[11:2]);

  always @(posedge clk) begin
    if (m_wr) begin
      wmem[m_addr[11:2]]   <= m_wdata;
      wvalid[m_addr[11:2]] <= 1'b1;
    end
  end

  data_memory_arbiter #(.DATAWIDTH_BUS(32), .WAIT_CYCLES(W)) u_dut (
    .MemArbiter_CLOCK_50   (clk),
    .MemArbiter_RESET_InLow(rst_n),
    .Fetch_Req             (f_req),
    .Fetch_Address_In      (f_addr),
    .Fetch_Ack             (f_ack),
    .Fetch_Data_Out        (f_data),
    .LS_Req                (ls_req),
    .LS_WR                 (ls_wr),
    .LS_Address_In         (ls_addr),
    .LS_Data_In            (ls_wdata),
    .LS_Ack                (ls_ack),
    .LS_Data_Out           (ls_data),
    .LS_Error              (ls_err),
    .DataMemory_Address_Out(m_addr),
    .DataMemory_WrData_Out (m_wdata),
    .DataMemory_Selector_RD(m_rd),
    .DataMemory_Selector_WR(m_wr),
    .DataMemory_Data_In    (m_rdata),
    .MemArbiter_Busy       (busy)
  );

  data_memory_arbiter #(.DATAWIDTH_BUS(32), .WAIT_CYCLES(0)) u_dut0 (
    .MemArbiter_CLOCK_50   (clk),
    .MemArbiter_RESET_InLow(rst_n),
    .Fetch_Req             (1'b0),
    .Fetch_Address_In      (32'd0),
    .Fetch_Ack             (z_f_ack),
    .Fetch_Data_Out        (z_f_data),
    .LS_Req                (z_ls_req),
    .LS_WR                 (1'b0),
    .LS_Address_In         (z_ls_addr),
    .LS_Data_In            (32'd0),
    .LS_Ack                (z_ls_ack),
    .LS_Data_Out           (z_ls_data),
    .LS_Error              (z_ls_err),
    .DataMemory_Address_Out(z_addr),
    .DataMemory_WrData_Out (z_wdata),
    .DataMemory_Selector_RD(z_rd),
    .DataMemory_Selector_WR(z_wr),
    .DataMemory_Data_In    (z_rdata),
    .MemArbiter_Busy       (z_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: one call per request, in each port's request order.
  task automatic model_push(input logic ls, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wd);
    logic     mis;
    logic [9:0] idx;
    ls_exp_t  e;
    mis = AlignEn && (addr[1:0] != 2'b00);
    idx = addr[11:2];
    if (ls) begin
      if (!mis) begin
        if (wr) ref_mem[idx] = wd;
        else m_ls_last = ref_mem[idx];
      end
      e.data = m_ls_last;
      e.err  = mis;
      exp_ls.push_back(e);
    end else begin
      if (!mis) m_f_last = ref_mem[idx];
      exp_f.push_back(m_f_last);
    end
  endtask

  // Issue one request and wait (bounded) for its ack.
  // lat counts rising edges from issue to the edge that raises the ack.
  task automatic drive(input logic ls, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wd, input bit keep, output int lat,
                       output int rd_n, output int wr_n, output int wr_ok);
    logic ack;
    lat = 0; rd_n = 0; wr_n = 0; wr_ok = 0; ack = 1'b0;
    if (ls) begin
      ls_req = 1'b1; ls_wr = wr; ls_addr = addr; ls_wdata = wd;
    end else begin
      f_req = 1'b1; f_addr = addr;
    end
    model_push(ls, wr, addr, wd);
    while (!ack && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (m_rd) rd_n++;
      if (m_wr) wr_n++;
      if (m_wr && m_wdata == wd && m_addr == addr) wr_ok++;
      ack = ls ? ls_ack : f_ack;
    end
    if (!ack) begin
      if (ls) check("ls_ack_timeout", {31'd0, ack}, 32'd1);
      else check("fetch_ack_timeout", {31'd0, ack}, 32'd1);
    end
    if (!keep) begin
      if (ls) ls_req = 1'b0;
      else f_req = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Monitor: per-cycle bus rules plus scoreboard pops on every ack.
  initial begin
    logic [31:0] ef;
    ls_exp_t     el;
    ack_rec_t    r;
    forever begin
      @(posedge clk); #1;
      if (rst_n) begin
        check("sel_onehot", {31'd0, m_rd & m_wr}, 32'd0);
        check("dual_ack", {31'd0, f_ack & ls_ack}, 32'd0);
        check("err_without_ack", {31'd0, ls_err & ~ls_ack}, 32'd0);
        if (!m_rd && !m_wr) check("bus_idle_zero", m_addr | m_wdata, 32'd0);
        if (m_rd || m_wr || f_ack || ls_ack) check("busy", {31'd0, busy}, 32'd1);
        if (f_ack) begin
          r.ls = 1'b0; r.cyc = cyc; ack_log.push_back(r);
          if (exp_f.size() == 0) begin
            check("fetch_ack_unexpected", {31'd0, f_ack}, 32'd0);
          end else begin
            ef = exp_f.pop_front();
            check("fetch_data", f_data, ef);
          end
        end
        if (ls_ack) begin
          r.ls = 1'b1; r.cyc = cyc; ack_log.push_back(r);
          if (exp_ls.size() == 0) begin
            check("ls_ack_unexpected", {31'd0, ls_ack}, 32'd0);
          end else begin
            el = exp_ls.pop_front();
            check("ls_data", ls_data, el.data);
            check("ls_error", {31'd0, ls_err}, {31'd0, el.err});
          end
        end
      end
    end
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, rd_n, wr_n, wr_ok, n;
    logic [3:0] order;
    rst_n = 1'b0;
    f_req = 1'b0; f_addr = '0;
    ls_req = 1'b0; ls_wr = 1'b0; ls_addr = '0; ls_wdata = '0;
    z_ls_req = 1'b0; z_ls_addr = '0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(10'(i));
    m_ls_last = '0;
    m_f_last  = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_ctrl", {26'd0, f_ack, ls_ack, ls_err, m_rd, m_wr, busy}, 32'd0);
    check("reset_mem_addr", m_addr, 32'd0);
    check("reset_mem_wdata", m_wdata, 32'd0);
    check("reset_fetch_data", f_data, 32'd0);
    check("reset_ls_data", ls_data, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Zero-wait instance: load from 0x0, ack two edges after issue
    z_ls_req = 1'b1; z_ls_addr = 32'h0;
    lat = 0; rd_n = 0;
    while (!z_ls_ack && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (z_rd) rd_n++;
    end
    z_ls_req = 1'b0;
    check("w0_latency", lat, 32'd2);
    check("w0_rd_cycles", rd_n, 32'd1);
    check("w0_data", z_ls_data, 32'h1080_0800);
    check("w0_no_fetch_ack", {30'd0, z_f_ack, z_ls_err}, 32'd0);

    // Load then store: store must leave LS_Data_Out at the loaded value
    wait_idle();
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, lat, rd_n, wr_n, wr_ok);
    check("load_latency", lat, W + 2);
    check("load_rd_cycles", rd_n, W + 1);
    wait_idle();
    drive(1'b1, 1'b1, 32'h4, 32'hDEAD_BEEF, 1'b0, lat, rd_n, wr_n, wr_ok);
    check("store_latency", lat, W + 2);
    check("store_wr_cycles", wr_n, W + 1);
    check("store_rd_cycles", rd_n, 32'd0);
    check("store_bus_value", wr_ok, W + 1);

    // Fetch read from 0x800
    wait_idle();
    drive(1'b0, 1'b0, 32'h800, 32'h0, 1'b0, lat, rd_n, wr_n, wr_ok);
    check("fetch_latency", lat, W + 2);
    check("fetch_rd_cycles", rd_n, W + 1);
    check("fetch_wr_cycles", wr_n, 32'd0);

    // Contention: both held, last grant was fetch -> LS, F, LS, F
    wait_idle();
    ack_log.delete();
    fork
      begin
        int l, r, w, o;
        drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, l, r, w, o);
        drive(1'b1, 1'b0, 32'h14, 32'h0, 1'b0, l, r, w, o);
      end
      begin
        int l, r, w, o;
        drive(1'b0, 1'b0, 32'h804, 32'h0, 1'b1, l, r, w, o);
        drive(1'b0, 1'b0, 32'h808, 32'h0, 1'b0, l, r, w, o);
      end
    join
    check("contention_acks", ack_log.size(), 32'd4);
    order = 4'b0101;  // bit i = 1 when the i-th ack is LS
    for (int i = 0; i < 4 && i < ack_log.size(); i++) begin
      check("contention_order", {31'd0, ack_log[i].ls}, {31'd0, order[i]});
      if (i > 0) check("contention_spacing", ack_log[i].cyc - ack_log[i-1].cyc, W + 3);
    end

    // Misaligned LS load from 0x802
    wait_idle();
    drive(1'b1, 1'b0, 32'h802, 32'h0, 1'b0, lat, rd_n, wr_n, wr_ok);
    check("misalign_latency", lat, AlignEn ? 32'd1 : W + 2);
    check("misalign_rd_cycles", rd_n, AlignEn ? 32'd0 : W + 1);
    check("misalign_wr_cycles", wr_n, 32'd0);

    // Reset in the second ACCESS cycle of a load from 0x8
    wait_idle();
    ls_req = 1'b1; ls_wr = 1'b0; ls_addr = 32'h8;
    @(posedge clk);
    @(posedge clk); #1;
    check("reset_test_in_access", {31'd0, m_rd}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    ls_req = 1'b0;
    check("midreset_ctrl", {26'd0, f_ack, ls_ack, ls_err, m_rd, m_wr, busy}, 32'd0);
    check("midreset_mem_addr", m_addr, 32'd0);
    check("midreset_ls_data", ls_data, 32'd0);
    check("midreset_fetch_data", f_data, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_ls_last = '0;
    m_f_last  = '0;
    repeat (3) @(negedge clk);
    wait_idle();
    drive(1'b1, 1'b0, 32'h8, 32'h0, 1'b0, lat, rd_n, wr_n, wr_ok);
    check("post_reset_latency", lat, W + 2);

    // Randomized traffic on both ports; LS and fetch regions do not overlap
    fork
      begin
        int l, r, w, o;
        logic [31:0] a;
        for (int t = 0; t < 25; t++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          a = 32'h800 + ($urandom_range(0, 255) << 2);
          if ($urandom_range(0, 7) == 0) a = a + $urandom_range(1, 3);
          drive(1'b0, 1'b0, a, 32'h0, 1'b0, l, r, w, o);
        end
      end
      begin
        int l, r, w, o;
        logic [31:0] a;
        for (int t = 0; t < 40; t++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          a = $urandom_range(0, 31) << 2;
          if ($urandom_range(0, 7) == 0) a = a + $urandom_range(1, 3);
          drive(1'b1, 1'($urandom_range(0, 1)), a, $urandom, 1'b0, l, r, w, o);
        end
      end
    join

    wait_idle();
    repeat (3) @(negedge clk);
    n = exp_f.size() + exp_ls.size();
    check("scoreboard_drained", n, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_memory_arbiter.md
# data_memory_arbiter

Sequential arbiter that shares the single combinational `Data_Memory` port between the instruction-fetch unit and the load/store unit of the processor. It grants one requester at a time and drives the memory address, write data and RD/WR selectors for a fixed, parameterised number of cycles. It registers the read data and returns it with a one-cycle acknowledge pulse. Arbitration gives load/store priority, with anti-starvation alternation for fetch.

## Interface
- `DATAWIDTH_BUS`, 32, width of address and data buses.
- `WAIT_CYCLES`, 1, extra cycles the memory bus is held before read data is captured (legal 0..15).

Ports:
- `MemArbiter_CLOCK_50` in 1, single system clock; all state updates on its rising edge.
- `MemArbiter_RESET_InLow` in 1, reset, asynchronous and active-low.
- `Fetch_Req` in 1, fetch request; held high until `Fetch_Ack`.
- `Fetch_Address_In` in DATAWIDTH_BUS, fetch byte address.
- `Fetch_Ack` out 1, one-cycle completion pulse.
- `Fetch_Data_Out` out DATAWIDTH_BUS, registered instruction word.
- `LS_Req` in 1, load/store request; held high until `LS_Ack`.
- `LS_WR` in 1, 1 = store, 0 = load.
- `LS_Address_In` in DATAWIDTH_BUS, load/store byte address.
- `LS_Data_In` in DATAWIDTH_BUS, store data.
- `LS_Ack` out 1, one-cycle completion pulse.
- `LS_Data_Out` out DATAWIDTH_BUS, registered load data.
- `LS_Error` out 1, misalignment flag, valid with `LS_Ack` (see Configuration).
- `DataMemory_Address_Out` out DATAWIDTH_BUS, to memory address.
- `DataMemory_WrData_Out` out DATAWIDTH_BUS, to memory write data.
- `DataMemory_Selector_RD` out 1, memory read select.
- `DataMemory_Selector_WR` out 1, memory write select.
- `DataMemory_Data_In` in DATAWIDTH_BUS, read data from memory.
- `MemArbiter_Busy` out 1, high in ACCESS and DONE.

## Operation
- The FSM has three states: IDLE, ACCESS, DONE.
- **IDLE**
  - Samples the requests.
  - Grant rule: LS wins, unless the last grant was LS and `Fetch_Req` is high; in that case fetch wins. Under continuous contention the grants therefore alternate.
  - On a grant, latch the address, write data, WR flag (forced to 0 for fetch) and grant ID; load the counter with WAIT_CYCLES; go to ACCESS.
  - With no request, stay in IDLE.
- **ACCESS**
  - Drive the memory bus from the latched registers.
  - `Selector_RD` = ~wr and `Selector_WR` = wr; exactly one selector is high.
  - If the counter is nonzero, decrement it. If it is 0, capture `DataMemory_Data_In` into the granted port's `*_Data_Out` (loads and fetches only) and go to DONE.
- **DONE**
  - Assert the granted port's `*_Ack` for exactly one cycle.
  - Memory outputs return to 0.
  - Go to IDLE. No grant is made in DONE.
- Dropping a request mid-access does not abort the access; it completes and acks normally.
- `*_Data_Out` holds its value until the next ack on the same port. Stores leave `LS_Data_Out` unchanged.
- Memory outputs are all 0 in IDLE and DONE.
- `LS_Address_In` and `Fetch_Address_In` are ignored outside IDLE.

## Timing
- A request sampled in IDLE at edge N gives:
  - ACCESS for WAIT_CYCLES+1 cycles.
  - Ack high in cycle N+WAIT_CYCLES+2.
  - IDLE again at N+WAIT_CYCLES+3.
- Back-to-back throughput is one access per WAIT_CYCLES+3 cycles.
- Reset values: every output is 0, state IDLE, counter 0, last-grant = fetch.
- Reset asserted mid-operation:
  - Immediate abort; all outputs return to 0 asynchronously and no ack is issued.
  - Requesters must re-request after reset.
- Simultaneous `Fetch_Req` and `LS_Req` from reset: LS is granted first.

## Configuration
- Macro: `DATA_MEMORY_ARBITER_ALIGN_CHECK_EN`.
- **Defined:** in IDLE, a granted access with address[1:0] ≠ 0 goes directly to DONE.
  - No selector asserts and `*_Data_Out` is unchanged.
  - For LS, `LS_Ack` and `LS_Error` pulse together.
  - For fetch, `Fetch_Ack` pulses and `LS_Error` stays 0.
- **Undefined:** `LS_Error` is tied 0 and all addresses are passed to memory unchanged.

## Test plan
1. **Fetch read.** WAIT_CYCLES=1; `Fetch_Req` with address 0x00000800.
   - `Selector_RD` high for 2 cycles.
   - `Fetch_Ack` pulses in cycle 3 after the sampling edge.
   - `Fetch_Data_Out` = 0xC2002004.
2. **Store.** `LS_Req` with WR=1, address 0x00000004, data 0xDEADBEEF.
   - `Selector_WR` high and `Selector_RD` low for WAIT_CYCLES+1 cycles; `DataMemory_WrData_Out` = 0xDEADBEEF.
   - `LS_Ack` pulses once and `LS_Data_Out` is unchanged.
3. **Contention.** `Fetch_Req` and `LS_Req` held continuously.
   - Grant order is LS, F, LS, F.
   - Acks are spaced WAIT_CYCLES+3 cycles apart.
4. **Reset mid-access.** Deassert `MemArbiter_RESET_InLow` in the 2nd ACCESS cycle of a load from 0x00000008.
   - All outputs go to 0 at once and no `LS_Ack` appears.
   - After release, the next request completes normally and returns 0x0000000A.
5. **Misaligned address (macro defined).** LS load from 0x00000802.
   - `LS_Ack` and `LS_Error` pulse together 1 cycle after the grant; no selector asserts.
6. **WAIT_CYCLES=0.** Load from 0x00000000.
   - Ack arrives 2 cycles after sampling with data 0x10800800.
